// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, RV32 opcode and
// funct fields, and the FSM state encoding.
package alu_issue_pkg;

  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b1101;
  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b0010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_t;

endpackage

// File: rtl/alu_issue_imm_gen.sv
// Combinational I- and B-type immediate extraction from an RV32 instruction word.
module alu_issue_imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_b
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  logic unused_bits;
  assign unused_bits = ^{instr[19:12], instr[6:0]};

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller in front of the ALU: accept, decode, wait EXEC_CYCLES,
// then pulse writeback / branch / illegal. BNE decode enabled by BRANCH_NE_SUPPORT_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [3:0]      ALUOperation,
  output logic [XLEN-1:0] Data1_RF,
  output logic [XLEN-1:0] Data2_shift_cond_mux,
  output logic [4:0]      shamt,
  input  logic [XLEN-1:0] ALUResult_ALU,
  input  logic            ZeroFlag,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            branch_valid,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_offset,
  output logic            illegal_instr
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t          state;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rs1_q, rs2_q, res_q;
  logic [3:0]      cnt;
  logic            ill_q, br_q, bne_q, zf_q;
  logic [XLEN-1:0] imm_i, imm_b;

  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_sh;
  logic            dec_ill, dec_br, dec_bne;

  wire [6:0] opc = instr_q[6:0];
  wire [2:0] f3  = instr_q[14:12];
  wire [6:0] f7  = instr_q[31:25];
  wire [4:0] rd  = instr_q[11:7];

  alu_issue_imm_gen u_imm (.instr(instr_q), .imm_i(imm_i), .imm_b(imm_b));

  always_comb begin
    dec_op  = ALU_ADD;
    dec_b   = rs2_q;
    dec_sh  = rs2_q[4:0];
    dec_ill = 1'b0;
    dec_br  = 1'b0;
    dec_bne = 1'b0;
    case (opc)
      OPC_OP: begin
        case (f3)
          F3_ADD: begin
            if (f7 == F7_BASE)     dec_op = ALU_ADD;
            else if (f7 == F7_ALT) dec_op = ALU_SUB;
            else                   dec_ill = 1'b1;
          end
          F3_AND: dec_op = ALU_AND;
          F3_OR:  dec_op = ALU_OR;
          F3_SLL: dec_op = ALU_SLL;
          F3_SRL: begin
            if (f7 == F7_BASE) dec_op = ALU_SRL;
            else               dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec_b  = imm_i;
        dec_sh = instr_q[24:20];
        case (f3)
          F3_ADD: dec_op = ALU_ADD;
          F3_AND: dec_op = ALU_AND;
          F3_OR:  dec_op = ALU_OR;
          F3_SLL: begin
            if (f7 == F7_BASE) dec_op = ALU_SLL;
            else               dec_ill = 1'b1;
          end
          F3_SRL: begin
            if (f7 == F7_BASE) dec_op = ALU_SRL;
            else               dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        // Branches compare via SUB; ZeroFlag resolves equality.
        dec_op = ALU_SUB;
        dec_br = 1'b1;
        case (f3)
          F3_BEQ: ;
`ifdef BRANCH_NE_SUPPORT_EN
          F3_BNE: dec_bne = 1'b1;
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                <= ST_IDLE;
      instr_ready          <= 1'b0;
      instr_q              <= '0;
      rs1_q                <= '0;
      rs2_q                <= '0;
      res_q                <= '0;
      cnt                  <= '0;
      ill_q                <= 1'b0;
      br_q                 <= 1'b0;
      bne_q                <= 1'b0;
      zf_q                 <= 1'b0;
      ALUOperation         <= ALU_ADD;
      Data1_RF             <= '0;
      Data2_shift_cond_mux <= '0;
      shamt                <= '0;
      wb_en                <= 1'b0;
      wb_rd                <= '0;
      wb_data              <= '0;
      branch_valid         <= 1'b0;
      branch_taken         <= 1'b0;
      branch_offset        <= '0;
      illegal_instr        <= 1'b0;
    end else begin
      wb_en         <= 1'b0;
      branch_valid  <= 1'b0;
      illegal_instr <= 1'b0;
      case (state)
        ST_IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            instr_q     <= instr;
            rs1_q       <= rs1_data;
            rs2_q       <= rs2_data;
            instr_ready <= 1'b0;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          ill_q <= dec_ill;
          br_q  <= dec_br;
          bne_q <= dec_bne;
          if (dec_ill) begin
            state <= ST_WB;
          end else begin
            ALUOperation         <= dec_op;
            Data1_RF             <= rs1_q;
            Data2_shift_cond_mux <= dec_b;
            shamt                <= dec_sh;
            cnt                  <= CNT_INIT;
            state                <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            res_q <= ALUResult_ALU;
            zf_q  <= ZeroFlag;
            state <= ST_WB;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WB: begin
          state       <= ST_IDLE;
          instr_ready <= 1'b1;
          if (ill_q) begin
            illegal_instr <= 1'b1;
          end else if (br_q) begin
            branch_valid  <= 1'b1;
            branch_taken  <= zf_q ^ bne_q;
            branch_offset <= imm_b;
          end else if (rd != 5'd0) begin
            wb_en   <= 1'b1;
            wb_rd   <= rd;
            wb_data <= res_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench: two controller instances (EXEC_CYCLES 1 and 4), each with an ALU model;
// directed and random instructions checked against a decode-table reference model.
module tb_alu_issue_ctrl;

  localparam int NL = 2;

  typedef struct {
    int          kind;   // 0 none, 1 writeback, 2 branch, 3 illegal
    logic [4:0]  rd;
    logic [31:0] data;
    logic        taken;
    logic [31:0] off;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    bit          chk_sh;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NL-1:0]       rst_n, instr_valid, instr_ready, zero_flag;
  logic [NL-1:0]       wb_en, branch_valid, branch_taken, illegal_instr;
  logic [NL-1:0][31:0] instr, rs1_data, rs2_data, data1, data2, alu_res, wb_data, branch_offset;
  logic [NL-1:0][3:0]  alu_op;
  logic [NL-1:0][4:0]  shamt, wb_rd;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b1000: return a + b;
      4'b1010: return a - b;
      4'b1100: return a & b;
      4'b1101: return a | b;
      4'b0000: return a << sh;
      4'b0010: return a >> sh;
      default: return 32'h0;
    endcase
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    alu_issue_ctrl #(.XLEN(32), .EXEC_CYCLES(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .reset_n(rst_n[g]),
      .instr_valid(instr_valid[g]), .instr_ready(instr_ready[g]), .instr(instr[g]),
      .rs1_data(rs1_data[g]), .rs2_data(rs2_data[g]),
      .ALUOperation(alu_op[g]), .Data1_RF(data1[g]), .Data2_shift_cond_mux(data2[g]),
      .shamt(shamt[g]), .ALUResult_ALU(alu_res[g]), .ZeroFlag(zero_flag[g]),
      .wb_en(wb_en[g]), .wb_rd(wb_rd[g]), .wb_data(wb_data[g]),
      .branch_valid(branch_valid[g]), .branch_taken(branch_taken[g]),
      .branch_offset(branch_offset[g]), .illegal_instr(illegal_instr[g])
    );
    assign alu_res[g]   = alu_model(alu_op[g], data1[g], data2[g], shamt[g]);
    assign zero_flag[g] = (alu_res[g] == 32'h0);
  end

  function automatic int ec(input int l);
    return (l == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d @cyc %0d: got %h want %h", nm, l, cyc, act, exp);
    end
  endtask

  // Reference decode: opcode/funct table -> function, then plain arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int fn;
    bit imm;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [12:0] bi;
    logic [31:0] opb;
    logic [4:0] sh;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    fn = -1; imm = 0;
    if (opc == 7'h33) begin
      case (f3)
        3'd0: fn = (f7 == 7'h00) ? 0 : (f7 == 7'h20) ? 1 : -1;
        3'd7: fn = 2;
        3'd6: fn = 3;
        3'd1: fn = 4;
        3'd5: fn = (f7 == 7'h00) ? 5 : -1;
        default: fn = -1;
      endcase
    end else if (opc == 7'h13) begin
      imm = 1;
      case (f3)
        3'd0: fn = 0;
        3'd7: fn = 2;
        3'd6: fn = 3;
        3'd1: fn = (f7 == 7'h00) ? 4 : -1;
        3'd5: fn = (f7 == 7'h00) ? 5 : -1;
        default: fn = -1;
      endcase
    end else if (opc == 7'h63) begin
      if (f3 == 3'd0) fn = 6;
`ifdef BRANCH_NE_SUPPORT_EN
      else if (f3 == 3'd1) fn = 7;
`endif
    end
    opb = imm ? {{20{ins[31]}}, ins[31:20]} : b;
    sh  = imm ? ins[24:20] : b[4:0];
    bi  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    e.rd = ins[11:7]; e.a = a; e.b = opb; e.sh = sh; e.chk_sh = (fn >= 0 && fn <= 5);
    e.taken = 1'b0; e.off = {{19{bi[12]}}, bi}; e.data = 32'h0; e.op = 4'h0; e.due = 0;
    case (fn)
      0: begin e.op = 4'b1000; e.data = a + opb; end
      1: begin e.op = 4'b1010; e.data = a - opb; end
      2: begin e.op = 4'b1100; e.data = a & opb; end
      3: begin e.op = 4'b1101; e.data = a | opb; end
      4: begin e.op = 4'b0000; e.data = a << sh; end
      5: begin e.op = 4'b0010; e.data = a >> sh; end
      6: begin e.op = 4'b1010; e.taken = (a == b); end
      7: begin e.op = 4'b1010; e.taken = (a != b); end
      default: ;
    endcase
    if (fn < 0)       e.kind = 3;
    else if (fn >= 6) e.kind = 2;
    else              e.kind = (e.rd == 5'd0) ? 0 : 1;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, r2, r1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [6:0] f7;
    k = $urandom_range(0, 9);
    rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom); f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2:    f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (k <= 3)      return enc_r(f7, r2, r1, f3, rd, 7'b0110011);
    else if (k <= 6) return enc_r(f7, r2, r1, f3, rd, 7'b0010011);
    else if (k <= 8) return enc_b(int'($urandom_range(0, 8191)), r2, r1,
                                  ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1)));
    else             return $urandom;
  endfunction

  task automatic send(input int l, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input bit push);
    exp_t e;
    int n;
    @(negedge clk);
    instr[l] = ins; rs1_data[l] = a; rs2_data[l] = b; instr_valid[l] = 1'b1;
    n = 0;
    while (!instr_ready[l] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", l, 32'(instr_ready[l]), 32'd1);
    if (!instr_ready[l]) begin
      instr_valid[l] = 1'b0;
      return;
    end
    e = model(ins, a, b);
    e.due = cyc + 1 + ((e.kind == 3) ? 2 : 2 + ec(l));
    if (push && e.kind != 0) begin
      if (l == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1 instr_valid[l] = 1'b0;
  endtask

  task automatic check_pulse(input int l);
    exp_t e;
    logic [2:0] got, want;
    got = {wb_en[l], branch_valid[l], illegal_instr[l]};
    if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0)) begin
      chk("unexpected_pulse", l, 32'(got), 32'd0);
      return;
    end
    if (l == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    want = (e.kind == 1) ? 3'b100 : (e.kind == 2) ? 3'b010 : 3'b001;
    chk("pulse_cycle", l, cyc, e.due);
    chk("pulse_kind", l, 32'(got), 32'(want));
    if (e.kind == 1) begin
      chk("wb_rd", l, 32'(wb_rd[l]), 32'(e.rd));
      chk("wb_data", l, wb_data[l], e.data);
    end
    if (e.kind == 2) begin
      chk("branch_taken", l, 32'(branch_taken[l]), 32'(e.taken));
      chk("branch_offset", l, branch_offset[l], e.off);
    end
    if (e.kind != 3) begin
      chk("alu_op", l, 32'(alu_op[l]), 32'(e.op));
      chk("alu_a", l, data1[l], e.a);
      chk("alu_b", l, data2[l], e.b);
      if (e.chk_sh) chk("shamt", l, 32'(shamt[l]), 32'(e.sh));
    end
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++)
      if (wb_en[l] || branch_valid[l] || illegal_instr[l]) check_pulse(l);
  end

  task automatic chk_reset(input int l);
    chk("rst_ready", l, 32'(instr_ready[l]), 32'd0);
    chk("rst_alu_op", l, 32'(alu_op[l]), 32'h8);
    chk("rst_operands", l, data1[l] | data2[l] | 32'(shamt[l]), 32'd0);
    chk("rst_wb", l, wb_data[l] | 32'(wb_rd[l]) | branch_offset[l], 32'd0);
    chk("rst_pulses", l, 32'({wb_en[l], branch_valid[l], branch_taken[l], illegal_instr[l]}), 32'd0);
  endtask

  initial begin
    rst_n = '0; instr_valid = '1; rs1_data = '0; rs2_data = '0;
    for (int l = 0; l < NL; l++) instr[l] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0110011);
    repeat (3) @(negedge clk);
    for (int l = 0; l < NL; l++) chk_reset(l);
    rst_n = '1;
    @(negedge clk);
    for (int l = 0; l < NL; l++) chk("ready_after_reset", l, 32'(instr_ready[l]), 32'd1);
    instr_valid = '0;
    repeat (10) @(negedge clk);

    for (int l = 0; l < NL; l++) begin
      send(l, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0110011), 32'd7, 32'd5, 1);   // ADD x5,x1,x2
      send(l, enc_r(7'h00, 5'd4, 5'd1, 3'd5, 5'd3, 7'b0010011), 32'h80000000, $urandom, 1); // SRLI x3
      send(l, enc_r(7'h00, 5'd4, 5'd1, 3'd5, 5'd0, 7'b0010011), 32'h80000000, $urandom, 1); // rd=x0
      send(l, enc_b(-8, 5'd2, 5'd1, 3'd0), 32'd9, 32'd9, 1);                          // BEQ taken
      send(l, enc_b(-8, 5'd2, 5'd1, 3'd0), 32'd9, 32'd10, 1);                         // BEQ not taken
      send(l, 32'hFFFFFFFF, $urandom, $urandom, 1);
      send(l, enc_b(16, 5'd2, 5'd1, 3'd1), 32'd5, 32'd6, 1);                          // BNE
    end

    // Reset lane 1 while its ADD sits in EXEC: nothing may come out.
    send(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011), 32'd3, 32'd4, 0);
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset(1);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 1, 32'(instr_ready[1]), 32'd1);
    repeat (8) @(negedge clk);
    send(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011), 32'd100, 32'd23, 1);

    for (int i = 0; i < 150; i++) begin
      for (int l = 0; l < NL; l++) begin
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 1) == 0) ? a : $urandom;
        send(l, rand_instr(), a, b, 1);
      end
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 0, 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
